// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with a post-reset clear sweep and busy flag.
// Optional same-cycle write-to-read bypass is enabled by defining RF_BYPASS_EN.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] RdAddr,
    input  logic [DATA_W-1:0] RdData,
    input  logic [ADDR_W-1:0] RsAddr,
    input  logic [ADDR_W-1:0] RtAddr,
    output logic [DATA_W-1:0] RsData,
    output logic [DATA_W-1:0] RtData,
    output logic              busy,
    output logic              wr_drop
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t              state_r;
    state_t              stateNext_s;
    logic [ADDR_W-1:0]   clrIdx_r;
    logic [ADDR_W-1:0]   clrIdxNext_s;
    logic [DATA_W-1:0]   regs_r [DEPTH];
    logic                wrEn_s;
    logic [DATA_W-1:0]   rsData_s;
    logic [DATA_W-1:0]   rtData_s;

    function automatic logic isZeroAddr(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
    endfunction

    // State and sweep-index registers; reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= CLEAR;
            clrIdx_r <= {ADDR_W{1'b0}};
        end else begin
            state_r  <= stateNext_s;
            clrIdx_r <= clrIdxNext_s;
        end
    end

    // Next-state logic: the index holds at the last entry rather than wrapping.
    always_comb begin
        stateNext_s  = state_r;
        clrIdxNext_s = clrIdx_r;
        case (state_r)
            CLEAR: begin
                if (clrIdx_r == LAST_IDX) begin
                    stateNext_s = RUN;
                end else begin
                    clrIdxNext_s = clrIdx_r + ADDR_W'(1);
                end
            end
            RUN: begin
                stateNext_s = RUN;
            end
            default: begin
                stateNext_s  = CLEAR;
                clrIdxNext_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    assign wrEn_s = (state_r == RUN) && RegWrite && !isZeroAddr(RdAddr);

    // Storage array: cleared one entry per cycle in CLEAR, written by the port in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_r == CLEAR) begin
                regs_r[clrIdx_r] <= {DATA_W{1'b0}};
            end else if (wrEn_s) begin
                regs_r[RdAddr] <= RdData;
            end
        end
    end

    // Read ports: forced to zero while clearing and for the hardwired zero entry.
    always_comb begin
        rsData_s = {DATA_W{1'b0}};
        rtData_s = {DATA_W{1'b0}};
        if (state_r == RUN) begin
            if (isZeroAddr(RsAddr)) begin
                rsData_s = {DATA_W{1'b0}};
            end else begin
                rsData_s = regs_r[RsAddr];
            end
            if (isZeroAddr(RtAddr)) begin
                rtData_s = {DATA_W{1'b0}};
            end else begin
                rtData_s = regs_r[RtAddr];
            end
`ifdef RF_BYPASS_EN
            if (wrEn_s && (RdAddr == RsAddr)) begin
                rsData_s = RdData;
            end else begin
                rsData_s = rsData_s;
            end
            if (wrEn_s && (RdAddr == RtAddr)) begin
                rtData_s = RdData;
            end else begin
                rtData_s = rtData_s;
            end
`endif
        end else begin
            rsData_s = {DATA_W{1'b0}};
            rtData_s = {DATA_W{1'b0}};
        end
    end

    assign RsData  = rsData_s;
    assign RtData  = rtData_s;
    assign busy    = (state_r == CLEAR);
    assign wr_drop = (state_r == CLEAR) && RegWrite;

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: default 32x32 instance plus a 16x8 instance without zero entry.
module tb_regfile_param;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        rstA = 1'b1, weA = 1'b0;
    logic [4:0]  waA = 5'd0, raA = 5'd0, rbA = 5'd0;
    logic [31:0] wdA = 32'd0;
    logic [31:0] rsA, rtA;
    logic        busyA, dropA;

    regfile_param dutA (
        .clk(clk), .rst(rstA), .RegWrite(weA), .RdAddr(waA), .RdData(wdA),
        .RsAddr(raA), .RtAddr(rbA), .RsData(rsA), .RtData(rtA),
        .busy(busyA), .wr_drop(dropA)
    );

    // Instance B: 16-bit x 8, ordinary entry 0
    logic        rstB = 1'b1, weB = 1'b0;
    logic [2:0]  waB = 3'd0, raB = 3'd0, rbB = 3'd0;
    logic [15:0] wdB = 16'd0;
    logic [15:0] rsB, rtB;
    logic        busyB, dropB;

    regfile_param #(.DATA_W(16), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0)) dutB (
        .clk(clk), .rst(rstB), .RegWrite(weB), .RdAddr(waB), .RdData(wdB),
        .RsAddr(raB), .RtAddr(rbB), .RsData(rsB), .RtData(rtB),
        .busy(busyB), .wr_drop(dropB)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t q[$];
    int nChecks = 0;
    int nPass   = 0;

    // Reference model for instance A
    logic [31:0] model [32];
    bit          mBusy = 1'b0;
    int          sweepLeft = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Drain expectations at the negative edge, away from the sampling edge.
    always @(negedge clk) begin
        item_t it;
        logic [31:0] obs;
        while (q.size() > 0) begin
            it = q.pop_front();
            case (it.sel)
                0: obs = rsA;
                1: obs = rtA;
                2: obs = {31'd0, busyA};
                3: obs = {31'd0, dropA};
                4: obs = {16'd0, rsB};
                5: obs = {16'd0, rtB};
                6: obs = {31'd0, busyB};
                7: obs = {31'd0, dropB};
                default: obs = 32'hxxxxxxxx;
            endcase
            checkVal(it.tag, obs, it.exp);
        end
    end

    function automatic logic [31:0] expRead(input logic [4:0] ra, input bit we,
                                            input logic [4:0] wa, input logic [31:0] wd);
        if (mBusy) return 32'd0;
        if (BYP && we && (wa == ra) && (wa != 5'd0)) return wd;
        if (ra == 5'd0) return 32'd0;
        return model[ra];
    endfunction

    task automatic stepA(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb, input bit chk, input string tag);
        rstA = r; weA = we; waA = wa; wdA = wd; raA = ra; rbA = rb;
        if (chk) begin
            q.push_back('{{tag, ".rs"},   0, expRead(ra, we, wa, wd)});
            q.push_back('{{tag, ".rt"},   1, expRead(rb, we, wa, wd)});
            q.push_back('{{tag, ".busy"}, 2, {31'd0, mBusy}});
            q.push_back('{{tag, ".drop"}, 3, {31'd0, mBusy && we}});
        end
        @(posedge clk);
        if (r) begin
            mBusy = 1'b1;
            sweepLeft = 32;
        end else if (mBusy) begin
            sweepLeft--;
            if (sweepLeft == 0) begin
                mBusy = 1'b0;
                for (int k = 0; k < 32; k++) model[k] = 32'd0;
            end
        end else if (we && (wa != 5'd0)) begin
            model[wa] = wd;
        end
        #1;
    endtask

    task automatic stepB(input bit r, input bit we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [2:0] ra, input logic [2:0] rb, input bit chk,
                         input logic [15:0] eRs, input logic [15:0] eRt,
                         input bit eBusy, input bit eDrop, input string tag);
        rstB = r; weB = we; waB = wa; wdB = wd; raB = ra; rbB = rb;
        if (chk) begin
            q.push_back('{{tag, ".rs"},   4, {16'd0, eRs}});
            q.push_back('{{tag, ".rt"},   5, {16'd0, eRt}});
            q.push_back('{{tag, ".busy"}, 6, {31'd0, eBusy}});
            q.push_back('{{tag, ".drop"}, 7, {31'd0, eDrop}});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sweepA(input string tag);
        for (int i = 0; i < 32; i++) begin
            logic [4:0] a = 5'(i);
            stepA(1'b0, (i == 4) || (i == 20), (i == 4) ? 5'd3 : 5'd9, 32'h000000FF,
                  a, 5'(31 - i), 1'b1, tag);
        end
        stepA(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd9, 1'b1, {tag, "_end"});
        for (int i = 0; i < 16; i++) begin
            stepA(1'b0, 1'b0, 5'd0, 32'd0, 5'(2 * i), 5'(2 * i + 1), 1'b1, {tag, "_zero"});
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) model[k] = 32'd0;
        // Reset and full sweep, with dropped writes during the sweep
        stepA(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, "rst");
        sweepA("sweep1");
        // Basic write/read and the hardwired zero entry
        stepA(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b1, "wr5");
        stepA(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b1, "rd5");
        stepA(1'b0, 1'b1, 5'd0, 32'h00001234, 5'd0, 5'd5, 1'b1, "wr0");
        stepA(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, "rd0");
        // Same-cycle write and read of one address
        stepA(1'b0, 1'b1, 5'd7, 32'h11111111, 5'd1, 5'd2, 1'b1, "pre7");
        stepA(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b1, "byp7");
        stepA(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b1, "rd7");
        for (int i = 0; i < 40; i++) begin
            stepA(1'b0, 1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                  5'($urandom), 5'($urandom), 1'b1, "rand");
        end
        // Reset from RUN, then again mid-sweep at cycle 10
        stepA(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd7, 1'b1, "rst2");
        for (int i = 0; i < 10; i++) begin
            stepA(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'd7, 1'b1, "part");
        end
        stepA(1'b1, 1'b1, 5'd3, 32'h000000FF, 5'd5, 5'd7, 1'b1, "rst3");
        sweepA("sweep2");

        // Instance B: 8-entry sweep, entry 0 writable
        stepB(1'b1, 1'b0, 3'd0, 16'd0, 3'd0, 3'd0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, "Brst");
        for (int i = 0; i < 8; i++) begin
            stepB(1'b0, i == 2, 3'd3, 16'h00FF, 3'(i), 3'(7 - i), 1'b1,
                  16'd0, 16'd0, 1'b1, i == 2, "Bsweep");
        end
        stepB(1'b0, 1'b0, 3'd0, 16'd0, 3'd3, 3'd0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, "Bdone");
        stepB(1'b0, 1'b1, 3'd0, 16'hBEEF, 3'd1, 3'd2, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, "Bwr0");
        stepB(1'b0, 1'b0, 3'd0, 16'd0, 3'd0, 3'd0, 1'b1, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, "Brd0");
        stepB(1'b0, 1'b0, 3'd0, 16'd0, 3'd0, 3'd3, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, "Bidle");

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
